// File: rtl/uart_loader.sv
// ---------------------------------------------------------------------------
// uart_loader
//
// Turns the UART receiver's byte stream into 32-bit RAM writes so a program
// image can be loaded. The CPU is held in reset while a frame is in
// progress and is released only when a frame completes without error.
//
// Frame: MAGIC, LEN_LO, LEN_HI, then LEN payload bytes packed little-endian
// into words at BASE_ADDR, BASE_ADDR+1, ... (address wraps at 2^ADDR_WIDTH).
//
// Build option:
//   UART_LOADER_CSUM_EN  - when defined, one trailing byte equal to the
//                          mod-256 sum of the payload must follow the
//                          payload before the load is accepted.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   rx_valid   one-cycle strobe, rx_data holds a received byte
//   rx_data    received byte
//   mem_we     write request, held until mem_ack
//   mem_addr   word address of the write
//   mem_wdata  write data, byte n on bits [8n+7:8n]
//   mem_wstrb  byte-lane enables
//   mem_ack    write accepted this cycle
//   busy       frame in progress
//   done       one-cycle pulse on a successful load
//   error      sticky error flag, cleared by the next MAGIC byte
//   cpu_rst_n  active-low CPU reset
// ---------------------------------------------------------------------------
module uart_loader #(
    parameter int         ADDR_WIDTH   = 16,
    parameter int         BASE_ADDR    = 0,
    parameter logic [7:0] MAGIC        = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_rst_n
);

    // state  | meaning
    // IDLE   | waiting for MAGIC, all other bytes dropped
    // LEN0   | expecting low byte of payload length
    // LEN1   | expecting high byte of payload length
    // DATA   | collecting payload bytes into the current word
    // WRITE  | mem_we asserted, waiting for mem_ack
    // CSUM   | expecting the checksum byte (checksum builds only)
    // FINISH | pulse done, release CPU reset
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN0   = 3'd1;
    localparam logic [2:0] S_LEN1   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd6;
`ifdef UART_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_PAYLOAD_END = S_CSUM;
`else
    localparam logic [2:0] S_PAYLOAD_END = S_FINISH;
`endif

    localparam int TMR_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMR_W-1:0]      TMR_LOAD  = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);

    logic [2:0]       state;
    logic [1:0]       lane;
    logic [15:0]      remaining;
    logic [TMR_W-1:0] tmr;
    logic             timed;
    logic             timeout;
`ifdef UART_LOADER_CSUM_EN
    logic [7:0]       sum;
`endif

    // Inter-byte timer runs only while waiting on the UART; WRITE is
    // excluded so a slow memory never looks like a stalled sender.
    always_comb begin
        timed = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
`ifdef UART_LOADER_CSUM_EN
        if (state == S_CSUM) begin
            timed = 1'b1;
        end
`endif
    end

    assign timeout = timed && !rx_valid && (tmr == '0);

    // Down-counter reloaded on every byte; terminal count zero is reached
    // TIMEOUT_CLKS-1 idle clocks after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= TMR_LOAD;
        end else if (rx_valid) begin
            tmr <= TMR_LOAD;
        end else if (timed && (tmr != '0)) begin
            tmr <= tmr - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lane      <= 2'd0;
            remaining <= 16'd0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_BASE;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b1;
`ifdef UART_LOADER_CSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            done <= 1'b0;

            if (timeout) begin
                error <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_valid && (rx_data == MAGIC)) begin
                            error     <= 1'b0;
                            busy      <= 1'b1;
                            cpu_rst_n <= 1'b0;
                            mem_addr  <= ADDR_BASE;
                            mem_wdata <= 32'd0;
                            mem_wstrb <= 4'd0;
                            lane      <= 2'd0;
`ifdef UART_LOADER_CSUM_EN
                            sum       <= 8'd0;
`endif
                            state     <= S_LEN0;
                        end
                    end

                    S_LEN0: begin
                        if (rx_valid) begin
                            remaining[7:0] <= rx_data;
                            state          <= S_LEN1;
                        end
                    end

                    S_LEN1: begin
                        if (rx_valid) begin
                            remaining[15:8] <= rx_data;
                            if ({rx_data, remaining[7:0]} == 16'd0) begin
                                state <= S_PAYLOAD_END;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end

                    S_DATA: begin
                        if (rx_valid) begin
                            mem_wdata[{lane, 3'b000} +: 8] <= rx_data;
                            mem_wstrb[lane] <= 1'b1;
                            lane            <= lane + 2'd1;
                            remaining       <= remaining - 16'd1;
`ifdef UART_LOADER_CSUM_EN
                            sum             <= sum + rx_data;
`endif
                            // Word full or last byte of the payload: the
                            // request goes out on the very next cycle.
                            if ((lane == 2'd3) || (remaining == 16'd1)) begin
                                mem_we <= 1'b1;
                                state  <= S_WRITE;
                            end
                        end
                    end

                    S_WRITE: begin
                        // A byte arriving here would have nowhere to go;
                        // it wins over a same-cycle ack and aborts.
                        if (rx_valid) begin
                            error  <= 1'b1;
                            mem_we <= 1'b0;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else if (mem_ack) begin
                            mem_we    <= 1'b0;
                            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                            mem_wstrb <= 4'd0;
                            mem_wdata <= 32'd0;
                            lane      <= 2'd0;
                            if (remaining != 16'd0) begin
                                state <= S_DATA;
                            end else begin
                                state <= S_PAYLOAD_END;
                            end
                        end
                    end

`ifdef UART_LOADER_CSUM_EN
                    S_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == sum) begin
                                state <= S_FINISH;
                            end else begin
                                error <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end
                        end
                    end
`endif

                    S_FINISH: begin
                        done      <= 1'b1;
                        cpu_rst_n <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end

                    default: begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_loader
//
// Directed frames are pushed through the loader. The expected memory writes
// of each frame are derived from the payload bytes (word i holds bytes
// 4i..4i+3, missing lanes zero and unstrobed) and kept in a queue; a monitor
// on the falling edge compares every accepted write, write-request hold,
// request latency and done pulse against that model. Small parameters are
// used so the timeout and address wrap are reachable quickly.
// ---------------------------------------------------------------------------
module tb_uart_loader;

    localparam int AW   = 16;
    localparam int BASE = 65535;
    localparam int TO   = 40;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          rx_valid  = 1'b0;
    logic [7:0]    rx_data   = 8'h00;
    logic          mem_ack   = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_rst_n;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_rx_cyc = 0;
    int  last_ack_cyc = 0;
    int  done_cyc = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  ack_delay = 0;
    bit  ack_enable = 1'b1;
    logic [31:0] last_wdata = 32'd0;
    logic [15:0] last_waddr = 16'd0;

    logic [7:0] pl[$];
    wr_t        exp_q[$];

    uart_loader #(
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (BASE),
        .MAGIC       (8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_rst_n(cpu_rst_n)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Expected word w of the current payload.
    function automatic void model_word(input int w, output wr_t r);
        r.addr = 16'(BASE + w);
        r.data = 32'd0;
        r.strb = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (4 * w + k < pl.size()) begin
                r.data[8*k +: 8] = pl[4*w+k];
                r.strb[k]        = 1'b1;
            end
        end
    endfunction

    function automatic void add_expected();
        wr_t r;
        for (int w = 0; w < (pl.size() + 3) / 4; w++) begin
            model_word(w, r);
            exp_q.push_back(r);
        end
    endfunction

`ifdef UART_LOADER_CSUM_EN
    function automatic logic [7:0] csum_of();
        logic [7:0] s;
        s = 8'd0;
        foreach (pl[i]) s = s + pl[i];
        return s;
    endfunction
`endif

    // Memory side: acknowledge after ack_delay extra cycles of mem_we.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (mem_we && ack_enable) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Compare process.
    initial begin
        logic        prev_we, prev_ack, prev_done;
        logic [15:0] prev_addr;
        logic [31:0] prev_data;
        logic [3:0]  prev_strb;
        wr_t         e;
        prev_we = 1'b0; prev_ack = 1'b0; prev_done = 1'b0;
        prev_addr = '0; prev_data = '0; prev_strb = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (mem_we && !prev_we)
                    chk("byte_to_we_latency", 32'(cyc - last_rx_cyc), 32'd1);
                if (mem_we && prev_we && !prev_ack) begin
                    chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
                    chk("hold_wdata", mem_wdata, prev_data);
                    chk("hold_wstrb", 32'(mem_wstrb), 32'(prev_strb));
                end
                if (mem_we && mem_ack) begin
                    wr_cnt++;
                    last_ack_cyc = cyc;
                    last_wdata   = mem_wdata;
                    last_waddr   = mem_addr;
                    if (exp_q.size() == 0) begin
                        chk("write_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 32'(mem_addr), 32'(e.addr));
                        chk("write_data", mem_wdata, e.data);
                        chk("write_strb", 32'(mem_wstrb), 32'(e.strb));
                    end
                end
                if (done) begin
                    chk1("done_one_cycle", prev_done, 1'b0);
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy)
                    chk1("cpu_held_while_busy", cpu_rst_n, 1'b0);
                if (rx_valid)
                    last_rx_cyc = cyc;
            end
            prev_we   = mem_we;
            prev_ack  = mem_ack;
            prev_done = done;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
            prev_strb = mem_wstrb;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit wait_wr);
        int budget;
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        if (wait_wr) begin
            budget = 200;
            while (mem_we && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) chk1("write_wait_bound", mem_we, 1'b0);
        end
        repeat (gap) tick();
    endtask

    task automatic send_frame(input int gap);
        send_byte(8'hA5, gap, 1'b1);
        chk1("magic_busy", busy, 1'b1);
        chk1("magic_cpu_rst", cpu_rst_n, 1'b0);
        chk1("magic_error_clear", error, 1'b0);
        send_byte(8'(pl.size()), gap, 1'b1);
        send_byte(8'(pl.size() >> 8), gap, 1'b1);
        foreach (pl[i]) send_byte(pl[i], gap, 1'b1);
`ifdef UART_LOADER_CSUM_EN
        send_byte(csum_of(), gap, 1'b1);
`endif
    endtask

    task automatic wait_done(input int d0);
        int budget;
        budget = 200;
        while (done_cnt == d0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_good(input int gap, input int delay);
        int w0, d0, nexp;
        ack_delay = delay;
        exp_q.delete();
        add_expected();
        nexp = exp_q.size();
        w0 = wr_cnt;
        d0 = done_cnt;
        send_frame(gap);
        wait_done(d0);
        tick();
        chk("frame_writes", 32'(wr_cnt - w0), 32'(nexp));
        chk("model_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_done_count", 32'(done_cnt - d0), 32'd1);
        chk1("frame_error", error, 1'b0);
        chk1("frame_busy", busy, 1'b0);
        chk1("frame_cpu_release", cpu_rst_n, 1'b1);
    endtask

    initial begin
        int  w0, d0;
        wr_t r;

        // ---------------- reset values ----------------
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk1("rst_we", mem_we, 1'b0);
        chk("rst_addr", 32'(mem_addr), 32'h0000FFFF);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_cpu", cpu_rst_n, 1'b1);
        rst_n = 1'b1;
        repeat (2) tick();

        // ---------------- non-MAGIC bytes in IDLE ----------------
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'h00, 1, 1'b1);
        send_byte(8'hFF, 1, 1'b1);
        send_byte(8'h5A, 3, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        chk1("idle_cpu", cpu_rst_n, 1'b1);
        chk("idle_writes", 32'(wr_cnt - w0), 32'd0);
        chk("idle_done", 32'(done_cnt - d0), 32'd0);

        // ---------------- 4-byte frame ----------------
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        model_word(0, r);
        chk("model_t1_data", r.data, 32'h44332211);
        chk("model_t1_strb", 32'(r.strb), 32'hF);
        run_good(1, 0);
        chk("t1_wdata", last_wdata, 32'h44332211);
        chk("t1_waddr", 32'(last_waddr), 32'h0000FFFF);
`ifndef UART_LOADER_CSUM_EN
        chk("ack_to_done", 32'(done_cyc - last_ack_cyc), 32'd2);
`endif

        // ---------------- 5-byte frame, partial word, address wrap ----------------
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        model_word(1, r);
        chk("model_t2_data", r.data, 32'h00000005);
        chk("model_t2_strb", 32'(r.strb), 32'h1);
        chk("model_t2_addr", 32'(r.addr), 32'h0);
        run_good(0, 0);
        chk("t2_last_wdata", last_wdata, 32'h00000005);
        chk("t2_addr_after", 32'(mem_addr), 32'h0001);

        // ---------------- slow memory, 10 extra ack cycles ----------------
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA};
        run_good(2, 10);

        // ---------------- zero-length frame ----------------
        pl.delete();
        run_good(1, 0);

        // ---------------- overrun during a delayed write ----------------
        ack_delay = 10;
        exp_q.delete();
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5, 1, 1'b1);
        send_byte(8'h04, 1, 1'b1);
        send_byte(8'h00, 1, 1'b1);
        send_byte(8'h11, 0, 1'b1);
        send_byte(8'h22, 0, 1'b1);
        send_byte(8'h33, 0, 1'b1);
        send_byte(8'h44, 0, 1'b0);
        repeat (3) tick();
        chk1("ovr_we_pending", mem_we, 1'b1);
        send_byte(8'h55, 0, 1'b0);
        chk1("ovr_error", error, 1'b1);
        chk1("ovr_we_drop", mem_we, 1'b0);
        chk1("ovr_busy", busy, 1'b0);
        chk1("ovr_cpu_held", cpu_rst_n, 1'b0);
        repeat (20) tick();
        chk("ovr_writes", 32'(wr_cnt - w0), 32'd0);
        chk("ovr_done", 32'(done_cnt - d0), 32'd0);
        chk1("ovr_error_sticky", error, 1'b1);

        // ---------------- overrun in the same cycle as mem_ack ----------------
        ack_delay = 0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.delete();
        add_expected();
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h04, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'h11, 0, 1'b1);
        send_byte(8'h22, 0, 1'b1);
        send_byte(8'h33, 0, 1'b1);
        send_byte(8'h44, 0, 1'b0);
        send_byte(8'h66, 0, 1'b0);
        chk1("ovr2_error", error, 1'b1);
        chk1("ovr2_busy", busy, 1'b0);
        chk1("ovr2_we", mem_we, 1'b0);
        repeat (10) tick();
        chk("ovr2_writes", 32'(wr_cnt - w0), 32'd1);
        chk("ovr2_done", 32'(done_cnt - d0), 32'd0);
        chk1("ovr2_cpu_held", cpu_rst_n, 1'b0);

        // good frame clears the error
        pl = '{8'hA0, 8'hB1, 8'hC2};
        run_good(1, 3);

        // ---------------- timeout after MAGIC ----------------
        exp_q.delete();
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5, 0, 1'b1);
        repeat (TO - 1) tick();
        chk1("to_not_yet", error, 1'b0);
        chk1("to_busy_before", busy, 1'b1);
        tick();
        chk1("to_error", error, 1'b1);
        chk1("to_busy", busy, 1'b0);
        chk1("to_cpu_held", cpu_rst_n, 1'b0);
        repeat (5) tick();
        chk("to_writes", 32'(wr_cnt - w0), 32'd0);
        chk("to_done", 32'(done_cnt - d0), 32'd0);

        pl = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
        run_good(1, 1);

        // ---------------- longest allowed gap between bytes ----------------
        pl = '{8'h7E, 8'h81, 8'hC3};
        run_good(TO - 1, 0);

`ifdef UART_LOADER_CSUM_EN
        // ---------------- checksum good / bad ----------------
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk("model_csum", 32'(csum_of()), 32'h0A);
        run_good(1, 0);

        ack_delay = 0;
        exp_q.delete();
        add_expected();
        w0 = wr_cnt; d0 = done_cnt;
        send_byte(8'hA5, 1, 1'b1);
        send_byte(8'h04, 1, 1'b1);
        send_byte(8'h00, 1, 1'b1);
        foreach (pl[i]) send_byte(pl[i], 1, 1'b1);
        send_byte(8'h0B, 1, 1'b1);
        repeat (5) tick();
        chk1("csum_bad_error", error, 1'b1);
        chk1("csum_bad_busy", busy, 1'b0);
        chk1("csum_bad_cpu", cpu_rst_n, 1'b0);
        chk("csum_bad_done", 32'(done_cnt - d0), 32'd0);
        chk("csum_bad_writes", 32'(wr_cnt - w0), 32'd1);
`endif

        // ---------------- reset while a write is pending ----------------
        ack_enable = 1'b0;
        exp_q.delete();
        w0 = wr_cnt;
        send_byte(8'hA5, 0, 1'b1);
        send_byte(8'h04, 0, 1'b1);
        send_byte(8'h00, 0, 1'b1);
        send_byte(8'hAA, 0, 1'b1);
        send_byte(8'hBB, 0, 1'b1);
        send_byte(8'hCC, 0, 1'b1);
        send_byte(8'hDD, 0, 1'b0);
        tick();
        chk1("mid_we_pending", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_we", mem_we, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_cpu", cpu_rst_n, 1'b1);
        chk("mid_rst_addr", 32'(mem_addr), 32'h0000FFFF);
        chk("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
        tick();
        rst_n = 1'b1;
        ack_enable = 1'b1;
        repeat (2) tick();
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd0);

        pl = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h24, 8'h68};
        run_good(0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
